// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the Y86 pipeline control unit: instruction codes,
// register and status encodings, FSM states and the control bundle type.
package pipe_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int STAT_W = 3;

    localparam logic [BYTE_W-1:0] IHALT   = 8'h0;
    localparam logic [BYTE_W-1:0] IMRMOVL = 8'h5;
    localparam logic [BYTE_W-1:0] IJXX    = 8'h7;
    localparam logic [BYTE_W-1:0] IRET    = 8'h9;
    localparam logic [BYTE_W-1:0] IPOPL   = 8'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SHLT = 3'd2;
    localparam logic [STAT_W-1:0] SADR = 3'd3;
    localparam logic [STAT_W-1:0] SINS = 3'd4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic set_cc;
        logic halted;
    } ctrl_t;

    // Instructions whose result arrives from memory (valM) and can cause load/use
    function automatic logic is_load(input logic [BYTE_W-1:0] icode);
        return (icode == IMRMOVL) || (icode == IPOPL);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Free-running up counter that sticks at all-ones instead of wrapping.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86 core: hazard stalls/bubbles,
// ret sequencing, exception drain/halt and performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] D_icode_i,
    input  logic [3:0]        d_srcA_i,
    input  logic [3:0]        d_srcB_i,
    input  logic [BYTE_W-1:0] E_icode_i,
    input  logic [3:0]        E_dstM_i,
    input  logic              e_Cnd_i,
    input  logic [STAT_W-1:0] m_stat_i,
    input  logic [STAT_W-1:0] W_stat_i,
    output logic              F_stall_o,
    output logic              D_stall_o,
    output logic              D_bubble_o,
    output logic              E_bubble_o,
    output logic              M_bubble_o,
    output logic              W_stall_o,
    output logic              set_cc_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  cyc_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic [1:0] state;
    logic [1:0] ret_cnt;
    logic       lu;
    logic       mp;
    logic       rd;
    logic       ret_act;
    logic       stat_ok;
    ctrl_t      ctrl;

    // The ret counter stands in for tracking the ret through E, M and W
    assign lu = is_load(E_icode_i) && (E_dstM_i != RNONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign mp      = (E_icode_i == IJXX) && !e_Cnd_i;
    assign rd      = (D_icode_i == IRET);
    assign ret_act = rd || (ret_cnt != 2'd0);
    assign stat_ok = (m_stat_i == SAOK) && (W_stat_i == SAOK);

    // Decode the control bundle from state and hazards; reset forces a clean pipe
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl.d_bubble = 1'b1;
            ctrl.e_bubble = 1'b1;
        end else begin
            case (state)
                ST_HALT: begin
                    ctrl.f_stall  = 1'b1;
                    ctrl.d_stall  = 1'b1;
                    ctrl.w_stall  = 1'b1;
                    ctrl.m_bubble = 1'b1;
                    ctrl.halted   = 1'b1;
                end
                ST_DRAIN: begin
                    ctrl.f_stall  = 1'b1;
                    ctrl.d_stall  = lu;
                    ctrl.d_bubble = mp || (!lu && ret_act);
                    ctrl.e_bubble = mp || lu;
                    ctrl.m_bubble = 1'b1;
                end
                default: begin
                    ctrl.f_stall  = lu || ret_act;
                    ctrl.d_stall  = lu;
                    ctrl.d_bubble = mp || (!lu && ret_act);
                    ctrl.e_bubble = mp || lu;
                    ctrl.set_cc   = stat_ok;
                end
            endcase
        end
    end

    assign F_stall_o  = ctrl.f_stall;
    assign D_stall_o  = ctrl.d_stall;
    assign D_bubble_o = ctrl.d_bubble;
    assign E_bubble_o = ctrl.e_bubble;
    assign M_bubble_o = ctrl.m_bubble;
    assign W_stall_o  = ctrl.w_stall;
    assign set_cc_o   = ctrl.set_cc;
    assign halted_o   = ctrl.halted;

    // Exception FSM: drain once M reports a fault, halt when it reaches W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (m_stat_i != SAOK) state <= ST_DRAIN;
                ST_DRAIN: if (W_stat_i != SAOK) state <= ST_HALT;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_RUN;
            endcase
        end
    end

    // Track the ret past D; a mispredict squashes it and halt freezes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_cnt <= 2'd0;
        end else if (state == ST_HALT) begin
            ret_cnt <= ret_cnt;
        end else if (mp) begin
            ret_cnt <= 2'd0;
        end else if (rd && !lu && (state == ST_RUN)) begin
            ret_cnt <= 2'd2;
        end else if (ret_cnt != 2'd0) begin
            ret_cnt <= ret_cnt - 2'd1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state != ST_HALT),
        .count (cyc_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == ST_RUN) && ctrl.f_stall),
        .count (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == ST_RUN) && (ctrl.d_bubble || ctrl.e_bubble)),
        .count (bubble_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, a mid-ret reset sequence and
// randomized traffic against a stage-position reference model.
module tb_pipe_ctrl;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0] d_icode;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [7:0] e_icode;
        logic [3:0] e_dstm;
        logic       cnd;
        logic [2:0] m_stat;
        logic [2:0] w_stat;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] ctrl;
        int         cyc;
        int         stall;
        int         bub;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [7:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [7:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, bubble_cnt;
    logic [7:0]       ctrl_act;

    int checks   = 0;
    int failures = 0;

    // reference model state: where a ret sits, run mode, counters
    bit ret_in_e, ret_in_m;
    int mode;
    int m_cyc, m_stall, m_bub;

    vec_t tbl [19];

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .D_icode_i    (D_icode),
        .d_srcA_i     (d_srcA),
        .d_srcB_i     (d_srcB),
        .E_icode_i    (E_icode),
        .E_dstM_i     (E_dstM),
        .e_Cnd_i      (e_Cnd),
        .m_stat_i     (m_stat),
        .W_stat_i     (W_stat),
        .F_stall_o    (F_stall),
        .D_stall_o    (D_stall),
        .D_bubble_o   (D_bubble),
        .E_bubble_o   (E_bubble),
        .M_bubble_o   (M_bubble),
        .W_stall_o    (W_stall),
        .set_cc_o     (set_cc),
        .halted_o     (halted),
        .cyc_cnt_o    (cyc_cnt),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

    assign ctrl_act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};

    // Free-running core clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t mk(input logic [7:0] d, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [7:0] e, input logic [3:0] dm, input logic c,
                               input logic [2:0] ms, input logic [2:0] ws);
        in_t v;
        v.d_icode = d; v.srca = sa; v.srcb = sb; v.e_icode = e;
        v.e_dstm = dm; v.cnd = c; v.m_stat = ms; v.w_stat = ws;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        D_icode = v.d_icode; d_srcA = v.srca; d_srcB = v.srcb; E_icode = v.e_icode;
        E_dstM = v.e_dstm; e_Cnd = v.cnd; m_stat = v.m_stat; W_stat = v.w_stat;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] c, input int cy, input int st, input int bb);
        check({tag, " ctrl"},   64'(ctrl_act),   64'(c));
        check({tag, " cyc"},    64'(cyc_cnt),    64'(cy));
        check({tag, " stall"},  64'(stall_cnt),  64'(st));
        check({tag, " bubble"}, 64'(bubble_cnt), 64'(bb));
    endtask

    // Assert reset from a falling edge, check forced outputs, release on the next falling edge
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_all({tag, " in-reset"}, 8'b0011_0000, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ret_in_e = 0; ret_in_m = 0; mode = 0;
        m_cyc = 0; m_stall = 0; m_bub = 0;
    endtask

    // One randomized cycle: drive, predict from the hazard rules, compare, advance the model
    task automatic rand_step(input int n, input bit allow_exc);
        logic [7:0] e_pool [7];
        logic [7:0] d_pool [4];
        in_t        v;
        bit         ld_use, misp, ret_d, busy, aok;
        logic [7:0] exp;
        e_pool = '{8'h0, 8'h1, 8'h5, 8'h7, 8'hB, 8'h2, 8'h6};
        d_pool = '{8'h0, 8'h1, 8'h2, 8'h6};
        v.d_icode = ($urandom_range(0, 3) == 0) ? 8'h9 : d_pool[$urandom_range(0, 3)];
        v.srca    = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        v.srcb    = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        v.e_icode = e_pool[$urandom_range(0, 6)];
        v.e_dstm  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        v.cnd     = 1'($urandom_range(0, 1));
        v.m_stat  = (allow_exc && $urandom_range(0, 14) == 0) ? 3'd3 : 3'd1;
        v.w_stat  = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'd1;
        drive(v);

        ld_use = (v.e_icode == 8'h5 || v.e_icode == 8'hB) && v.e_dstm != 4'hF &&
                 (v.e_dstm == v.srca || v.e_dstm == v.srcb);
        misp   = (v.e_icode == 8'h7) && !v.cnd;
        ret_d  = (v.d_icode == 8'h9);
        busy   = ret_d || ret_in_e || ret_in_m;
        aok    = (v.m_stat == 3'd1) && (v.w_stat == 3'd1);
        if (mode == 2)
            exp = 8'b1100_1101;
        else if (mode == 1)
            exp = {1'b1, ld_use, misp || (!ld_use && busy), misp || ld_use, 1'b1, 1'b0, 1'b0, 1'b0};
        else
            exp = {ld_use || busy, ld_use, misp || (!ld_use && busy), misp || ld_use, 1'b0, 1'b0, aok, 1'b0};
        check_all($sformatf("rand%0d", n), exp, m_cyc, m_stall, m_bub);

        if (mode != 2 && m_cyc < CMAX) m_cyc++;
        if (mode == 0 && exp[7] && m_stall < CMAX) m_stall++;
        if (mode == 0 && (exp[5] || exp[4]) && m_bub < CMAX) m_bub++;
        if (mode != 2) begin
            if (misp) begin
                ret_in_e = 0; ret_in_m = 0;
            end else begin
                ret_in_m = ret_in_e;
                ret_in_e = ret_d && !ld_use && (mode == 0);
            end
        end
        if (mode == 0 && v.m_stat != 3'd1)      mode = 1;
        else if (mode == 1 && v.w_stat != 3'd1) mode = 2;
        @(negedge clk);
    endtask

    // Main test sequence
    initial begin
        in_t nop;
        nop = mk(8'h1, 4'hF, 4'hF, 8'h1, 4'hF, 1'b1, 3'd1, 3'd1);
        tbl[0]  = '{nop,                                             8'b0000_0010,  0, 0, 0};
        tbl[1]  = '{mk(8'h1, 4'h0, 4'hF, 8'h5, 4'h0, 1, 3'd1, 3'd1), 8'b1101_0010,  1, 0, 0};
        tbl[2]  = '{mk(8'h1, 4'h0, 4'hF, 8'h0, 4'h0, 1, 3'd1, 3'd1), 8'b0000_0010,  2, 1, 1};
        tbl[3]  = '{mk(8'h9, 4'hF, 4'hF, 8'h1, 4'hF, 1, 3'd1, 3'd1), 8'b1010_0010,  3, 1, 1};
        tbl[4]  = '{nop,                                             8'b1010_0010,  4, 2, 2};
        tbl[5]  = '{nop,                                             8'b1010_0010,  5, 3, 3};
        tbl[6]  = '{nop,                                             8'b0000_0010,  6, 4, 4};
        tbl[7]  = '{mk(8'h9, 4'hF, 4'hF, 8'h7, 4'hF, 0, 3'd1, 3'd1), 8'b1011_0010,  7, 4, 4};
        tbl[8]  = '{nop,                                             8'b0000_0010,  8, 5, 5};
        tbl[9]  = '{mk(8'h9, 4'h4, 4'hF, 8'hB, 4'h4, 1, 3'd1, 3'd1), 8'b1101_0010,  9, 5, 5};
        tbl[10] = '{mk(8'h9, 4'h4, 4'hF, 8'h0, 4'hF, 1, 3'd1, 3'd1), 8'b1010_0010, 10, 6, 6};
        tbl[11] = '{nop,                                             8'b1010_0010, 11, 7, 7};
        tbl[12] = '{nop,                                             8'b1010_0010, 12, 8, 8};
        tbl[13] = '{nop,                                             8'b0000_0010, 13, 9, 9};
        tbl[14] = '{mk(8'h1, 4'hF, 4'hF, 8'h1, 4'hF, 1, 3'd3, 3'd1), 8'b0000_0000, 14, 9, 9};
        tbl[15] = '{mk(8'h1, 4'hF, 4'hF, 8'h1, 4'hF, 1, 3'd1, 3'd3), 8'b1000_1000, 15, 9, 9};
        tbl[16] = '{nop,                                             8'b1100_1101, 16, 9, 9};
        tbl[17] = '{nop,                                             8'b1100_1101, 16, 9, 9};
        tbl[18] = '{mk(8'h9, 4'hF, 4'hF, 8'h7, 4'hF, 0, 3'd1, 3'd1), 8'b1100_1101, 16, 9, 9};

        rst = 1'b0;
        drive(nop);
        check_all("por", 8'b0011_0000, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].in);
            check_all($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].cyc, tbl[i].stall, tbl[i].bub);
            @(negedge clk);
        end
        do_reset("halt-reset");

        // ret interrupted by reset leaves no residual bubbles
        drive(mk(8'h9, 4'hF, 4'hF, 8'h1, 4'hF, 1, 3'd1, 3'd1));
        check("midret d ctrl", 64'(ctrl_act), 64'(8'b1010_0010));
        @(negedge clk);
        drive(nop);
        check("midret e ctrl", 64'(ctrl_act), 64'(8'b1010_0010));
        @(negedge clk);
        do_reset("midret-reset");
        drive(nop);
        check_all("after-midret", 8'b0000_0010, 0, 0, 0);
        @(negedge clk);
        do_reset("pre-random");

        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 120; n++) rand_step(s * 1000 + n, n >= 70);
            do_reset($sformatf("seg%0d-reset", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 core (F, D, E, M, W).
- Sequences the fetch PC selector and the pipeline registers.
- Generates stall and bubble controls for three hazards: load/use, ret, and jXX mispredict.
- Owns the exception drain/halt state machine, the condition-code write enable and three free-running performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- D_icode_i  in  `BYTE  icode in the D register.
- d_srcA_i  in  4  decoded srcA (`RNONE = 4'hF).
- d_srcB_i  in  4  decoded srcB.
- E_icode_i  in  `BYTE  icode in the E register.
- E_dstM_i  in  4  dstM in the E register.
- e_Cnd_i  in  1  branch condition computed in E.
- m_stat_i  in  `STAT  status leaving the M stage.
- W_stat_i  in  `STAT  status in the W register.
- F_stall_o  out  1  hold the F register (predPC).
- D_stall_o  out  1  hold the D register.
- D_bubble_o  out  1  load a nop into D.
- E_bubble_o  out  1  load a nop into E.
- M_bubble_o  out  1  load a nop into M.
- W_stall_o  out  1  hold the W register.
- set_cc_o  out  1  condition-code write enable.
- halted_o  out  1  core has stopped.
- cyc_cnt_o  out  CNT_W  cycles since reset.
- stall_cnt_o  out  CNT_W  cycles with F_stall_o=1 in RUN.
- bubble_cnt_o  out  CNT_W  cycles with D_bubble_o or E_bubble_o = 1 in RUN.

Behaviour:
- Reset (rst=0, async):
  - State = RUN; ret_cnt = 0; all counters = 0.
  - While rst=0 the outputs are forced: stalls 0, D_bubble_o=1, E_bubble_o=1, M_bubble_o=0, set_cc_o=0, halted_o=0.
- Hazard terms (combinational):
  - lu = E_icode ∈ {IMRMOVL, IPOPL} and E_dstM ≠ RNONE and E_dstM ∈ {d_srcA, d_srcB}.
  - mp = E_icode==IJXX and !e_Cnd.
  - rd = D_icode==IRET.
- Ret sequencing uses a 2-bit counter, ret_cnt, in place of D/E/M icode compares.
  - ret_act = rd or ret_cnt≠0.
  - ret_cnt loads 2 when rd and !lu and !mp and state==RUN, i.e. the ret advances into E.
  - Otherwise ret_cnt decrements when nonzero.
  - Sequence: ret in D, then E (cnt=2), then M (cnt=1), then W (cnt=0). Fetch then uses W_valM via the PC selector.
- RUN outputs:
  - F_stall_o = lu or ret_act.
  - D_stall_o = lu.
  - D_bubble_o = mp or (!lu and ret_act).
  - E_bubble_o = mp or lu.
  - M_bubble_o = 0; W_stall_o = 0.
  - set_cc_o = 1 unless m_stat or W_stat ≠ SAOK.
- Simultaneous hazards:
  - lu and ret_act together: stall D, bubble E, no D bubble.
  - mp wins over ret: the cancelled ret does not load ret_cnt, and ret_cnt is cleared to 0.
- State machine:
  - RUN → DRAIN when m_stat ≠ SAOK.
  - DRAIN → HALT when W_stat ≠ SAOK.
  - HALT is sticky until reset.
- DRAIN outputs: M_bubble_o=1, set_cc_o=0, F_stall_o=1. The D/E controls keep their RUN values.
- HALT outputs:
  - F_stall_o=1, D_stall_o=1, W_stall_o=1, M_bubble_o=1.
  - D_bubble_o=0, E_bubble_o=0, set_cc_o=0, halted_o=1.
  - ret_cnt frozen.
- Counters:
  - All counters saturate at all-ones.
  - cyc_cnt increments every cycle in RUN and DRAIN and freezes in HALT.
  - stall_cnt and bubble_cnt increment only in RUN.
- Reset asserted mid-ret or mid-drain returns to RUN immediately; no residual bubbles after release.

Decomposition:
- Shared defines header: icode constants (IHALT=0, IJXX=7, IMRMOVL=5, IRET=9, IPOPL=0xB), RNONE, the `STAT` width and stat codes (SAOK=1, SHLT=2, SADR=3, SINS=4), and the FSM state encoding.
- One natural sub-module: sat_counter (CNT_W, inc, rst), instantiated three times.

Test Plan:
- Load/use:
  - Stimulus: E_icode=5, E_dstM=0, d_srcA=0, for 1 cycle.
  - Response: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt=1 and bubble_cnt=1.
  - Next cycle with E_icode=0 (bubble): all controls 0.
- Ret:
  - Stimulus: D_icode=9 for 1 cycle, then nops.
  - Response: F_stall=1 and D_bubble=1 for exactly 3 cycles; ret_cnt follows 2,1,0; 4th cycle all controls 0.
- Mispredict over ret:
  - Stimulus: E_icode=7, e_Cnd=0, D_icode=9 in the same cycle.
  - Response: D_bubble=1, E_bubble=1, F_stall=1 for that cycle only; next cycle F_stall=0 (ret_cnt stays 0).
- Load/use with ret in D:
  - Stimulus: E_icode=0xB, E_dstM=4, D_icode=9, d_srcA=4.
  - Response: D_stall=1, E_bubble=1, D_bubble=0; the next cycle (lu cleared) starts the 3-cycle ret sequence.
- Exception:
  - Stimulus: m_stat=3 at cycle N, W_stat=3 at N+1.
  - Response: N: set_cc=0. N+1: M_bubble=1, F_stall=1. N+2 onward: halted=1, W_stall=1, cyc_cnt frozen.
  - Then pulse rst low: halted=0, all counters 0.
